rp_sequencer: RTL and testbench

//  Controller between the math AXI slave and the reconfigurable partition (RP: ain, bin -> result).

---
 rtl/math_rp_pkg.sv | 23 ++
 rtl/rp_cycle_counter.sv | 29 ++
 rtl/rp_sequencer.sv | 139 +++++++++++++
 tb/tb_rp_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/math_rp_pkg.sv
// Shared definitions for the math reconfigurable-partition sequencer:
// FSM state encoding, default widths and a small sizing helper.
package math_rp_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned OP_COUNT_W     = 16;

  typedef enum logic [2:0] {
    StRprst    = 3'd0,
    StIdle     = 3'd1,
    StBusy     = 3'd2,
    StResp     = 3'd3,
    StDecouple = 3'd4
  } state_e;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rp_cycle_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
// Shared between RP latency wait and RP reset hold.
module rp_cycle_counter #(
  parameter int unsigned Width  = 2,
  parameter int unsigned RstVal = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= Width'(RstVal);
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rp_sequencer.sv
// Sequences operand pairs through the reconfigurable partition, returns results,
// and handles decoupling plus post-reconfiguration reset of the RP.
module rp_sequencer
  import math_rp_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned RP_LATENCY = 1,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [DATA_W-1:0]     rp_ain,
  output logic [DATA_W-1:0]     rp_bin,
  output logic                  rp_reset_n,
  input  logic [DATA_W-1:0]     rp_result,
  input  logic                  reconfig_req,
  input  logic                  reconfig_done,
  output logic                  decoupled,
  output logic [OP_COUNT_W-1:0] op_count
);

  localparam int unsigned CntW = cnt_width(RP_LATENCY, RST_CYCLES);

  state_e state_q, state_d;

  logic            cnt_zero;
  logic            cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_dec;
  logic            accept;
  logic            capture;
  logic            resp_done;

  logic [DATA_W-1:0]     rp_ain_q, rp_bin_q, out_result_q;
  logic [OP_COUNT_W-1:0] op_count_q;

  assign accept    = (state_q == StIdle) && in_valid && !reconfig_req;
  assign capture   = (state_q == StBusy) && cnt_zero;
  assign resp_done = (state_q == StResp) && out_ready;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= StRprst;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRprst:    if (cnt_zero) state_d = StIdle;
      StIdle: begin
        if (reconfig_req) begin
          state_d = StDecouple;
        end else if (in_valid) begin
          state_d = StBusy;
        end
      end
      StBusy:     if (cnt_zero) state_d = StResp;
      StResp:     if (out_ready) state_d = StIdle;
      StDecouple: if (reconfig_done) state_d = StRprst;
      default:    state_d = StRprst;
    endcase
  end

  // Outputs decoded from state; in_ready is masked while reset is asserted
  always_comb begin
    in_ready   = Reset_n && (state_q == StIdle) && !reconfig_req;
    out_valid  = (state_q == StResp);
    decoupled  = (state_q == StDecouple);
    rp_reset_n = (state_q == StIdle) || (state_q == StBusy) || (state_q == StResp);
  end

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = CntW'(RST_CYCLES - 1);
    if (accept) begin
      cnt_load     = 1'b1;
      cnt_load_val = CntW'(RP_LATENCY - 1);
    end else if ((state_q == StDecouple) && reconfig_done) begin
      cnt_load     = 1'b1;
      cnt_load_val = CntW'(RST_CYCLES - 1);
    end
  end

  assign cnt_dec = (state_q == StRprst) || (state_q == StBusy);

  rp_cycle_counter #(
    .Width  (CntW),
    .RstVal (RST_CYCLES - 1)
  ) u_cycle_counter (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Datapath; operands are cleared on entry to decouple so the RP sees idle inputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rp_ain_q     <= '0;
      rp_bin_q     <= '0;
      out_result_q <= '0;
      op_count_q   <= '0;
    end else begin
      if (accept) begin
        rp_ain_q <= in_a;
        rp_bin_q <= in_b;
      end else if ((state_q == StIdle) && reconfig_req) begin
        rp_ain_q <= '0;
        rp_bin_q <= '0;
      end
      if (capture) begin
        out_result_q <= rp_result;
      end
      if (resp_done) begin
        op_count_q <= op_count_q + OP_COUNT_W'(1);
      end
    end
  end

  assign rp_ain     = rp_ain_q;
  assign rp_bin     = rp_bin_q;
  assign out_result = out_result_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_rp_sequencer.sv
// Directed bench for rp_sequencer with an adder standing in for the RP.
module tb_rp_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] rp_ain;
  logic [31:0] rp_bin;
  logic        rp_reset_n;
  logic [31:0] rp_result;
  logic        reconfig_req;
  logic        reconfig_done;
  logic        decoupled;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  rp_sequencer #(
    .DATA_W     (32),
    .RP_LATENCY (1),
    .RST_CYCLES (4)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .rp_ain        (rp_ain),
    .rp_bin        (rp_bin),
    .rp_reset_n    (rp_reset_n),
    .rp_result     (rp_result),
    .reconfig_req  (reconfig_req),
    .reconfig_done (reconfig_done),
    .decoupled     (decoupled),
    .op_count      (op_count)
  );

  assign rp_result = rp_ain + rp_bin;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n       = 1'b0;
    in_valid      = 1'b0;
    in_a          = '0;
    in_b          = '0;
    out_ready     = 1'b0;
    reconfig_req  = 1'b0;
    reconfig_done = 1'b0;

    // 1: reset state and RP reset hold
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rp_reset_n", 32'(rp_reset_n), 32'd0);
    chk("rst_decoupled", 32'(decoupled), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_rp_ain", rp_ain, 32'd0);
    chk("rst_rp_bin", rp_bin, 32'd0);
    Reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rprst_low", 32'(rp_reset_n), 32'd0);
      chk("rprst_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("rprst_release", 32'(rp_reset_n), 32'd1);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 2: single add, latency 1
    in_a = 32'h5; in_b = 32'h7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t2_rp_ain", rp_ain, 32'h5);
    chk("t2_rp_bin", rp_bin, 32'h7);
    chk("t2_busy_out_valid", 32'(out_valid), 32'd0);
    chk("t2_busy_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_result", out_result, 32'hC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("t2_out_valid_drop", 32'(out_valid), 32'd0);
    chk("t2_op_count", 32'(op_count), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd1);

    // 3: backpressure
    in_a = 32'h10; in_b = 32'h20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_result", out_result, 32'h30);
      chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
      chk("t3_hold_count", 32'(op_count), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("t3_out_valid_drop", 32'(out_valid), 32'd0);
    chk("t3_op_count", 32'(op_count), 32'd2);
    tick();
    chk("t3_op_count_once", 32'(op_count), 32'd2);

    // 4: reconfig_req beats in_valid in IDLE
    in_a = 32'h3; in_b = 32'h4; in_valid = 1'b1; reconfig_req = 1'b1;
    #1;
    chk("t4_in_ready_masked", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t4_decoupled", 32'(decoupled), 32'd1);
    chk("t4_rp_reset_n", 32'(rp_reset_n), 32'd0);
    chk("t4_rp_ain_zero", rp_ain, 32'd0);
    chk("t4_rp_bin_zero", rp_bin, 32'd0);
    chk("t4_no_out_valid", 32'(out_valid), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t4_decoupled_hold", 32'(decoupled), 32'd1);
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    reconfig_req  = 1'b0;
    #1;
    chk("t4_recoupled", 32'(decoupled), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rprst_low", 32'(rp_reset_n), 32'd0);
      chk("t4_rprst_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("t4_rprst_release", 32'(rp_reset_n), 32'd1);
    chk("t4_in_ready_back", 32'(in_ready), 32'd1);
    chk("t4_op_count", 32'(op_count), 32'd2);

    // 5: reconfig_req during BUSY does not abort; wraps to zero
    in_a = 32'hFFFF_FFFF; in_b = 32'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reconfig_req = 1'b1;
    tick();
    chk("t5_out_valid", 32'(out_valid), 32'd1);
    chk("t5_out_result", out_result, 32'h0);
    chk("t5_not_decoupled", 32'(decoupled), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("t5_op_count", 32'(op_count), 32'd3);
    chk("t5_idle_decoupled", 32'(decoupled), 32'd0);
    chk("t5_idle_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t5_decoupled", 32'(decoupled), 32'd1);
    reconfig_done = 1'b1;
    tick();
    reconfig_done = 1'b0;
    reconfig_req  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_in_ready_back", 32'(in_ready), 32'd1);

    // 6: reset pulse during BUSY drops the operation
    in_a = 32'h1; in_b = 32'h2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    Reset_n  = 1'b0;
    #1;
    chk("t6_in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    Reset_n = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_op_count", 32'(op_count), 32'd0);
    chk("t6_rp_reset_n", 32'(rp_reset_n), 32'd0);
    chk("t6_rp_ain", rp_ain, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_out_valid", 32'(out_valid), 32'd0);
      chk("t6_rprst_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("t6_in_ready_back", 32'(in_ready), 32'd1);
    chk("t6_op_count_end", 32'(op_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
